// File: rtl/adc_if_pkg.sv
// Shared state encoding, frame-geometry defaults and timing helper for the
// modulo-ADC serial capture front end.
package adc_if_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } adc_state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_BITS  = FRAME_BITS - DATA_BITS;

    // Clock cycles from an accepted sample_tick to the data_valid pulse.
    function automatic int frame_latency(input int clk_div);
        return 2 * FRAME_BITS * clk_div + 2;
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period timer for the ADC serial clock: one-cycle strobe every CLK_DIV
// clk cycles, phase-aligned by i_restart.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_edge
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_edge = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_restart || o_edge)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/adc_spi_capture.sv
// Serial capture of the 12-bit modulo ADC: one 16-bit frame per accepted
// sample_tick, delivered as adc_data plus a one-cycle data_valid.
module adc_spi_capture #(
    parameter int CLK_DIV      = 2,
    parameter int FRAME_BITS   = adc_if_pkg::FRAME_BITS,
    parameter int DATA_BITS    = adc_if_pkg::DATA_BITS,
    parameter int LEAD_BITS    = FRAME_BITS - DATA_BITS,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sample_tick,
    input  logic                 clear_err,
    input  logic                 adc_sdata,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic [DATA_BITS-1:0] adc_data,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 frame_err
);

    import adc_if_pkg::*;

    localparam int EW = $clog2(FRAME_BITS + 1);
    localparam int QW = (QUIET_CYCLES > 2) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [EW-1:0] EDGE_LAST  = EW'(FRAME_BITS);
    // DONE already holds cs_n high for one cycle, so QUIET itself lasts one less.
    localparam logic [QW-1:0] QUIET_LAST = QW'((QUIET_CYCLES > 2) ? QUIET_CYCLES - 2 : 0);

    adc_state_t            r_state;
    logic [EW-1:0]         r_edge_cnt;
    logic [QW-1:0]         r_quiet_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  r_frame_err;

    logic w_accept;
    logic w_edge;
    logic w_last;
    logic w_lead_err;
    logic w_busy;

    assign w_busy     = (r_state != S_IDLE);
    assign w_accept   = (r_state == S_IDLE) && sample_tick && enable;
    assign w_last     = (r_state == S_SHIFT) && (r_edge_cnt == EDGE_LAST);
    assign w_lead_err = |r_shift[FRAME_BITS-1 -: LEAD_BITS];

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_restart (w_accept),
        .o_edge    (w_edge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_edge_cnt  <= '0;
            r_quiet_cnt <= '0;
            r_shift     <= '0;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state    <= S_SETUP;
                    r_cs_n     <= 1'b0;
                    r_edge_cnt <= '0;
                    r_shift    <= '0;
                end
                S_SETUP: if (w_edge) begin
                    r_sclk  <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: if (w_last) begin
                    r_state <= S_DONE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_data  <= r_shift[DATA_BITS-1:0];
                    r_valid <= 1'b1;
                end else if (w_edge) begin
                    r_sclk <= ~r_sclk;
                    // Sample on the edge that drives sclk high.
                    if (!r_sclk) begin
                        r_shift    <= {r_shift[FRAME_BITS-2:0], adc_sdata};
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_quiet_cnt <= '0;
                    r_state     <= (QUIET_CYCLES > 1) ? S_QUIET : S_IDLE;
                end
                S_QUIET: begin
                    if (r_quiet_cnt == QUIET_LAST)
                        r_state <= S_IDLE;
                    else
                        r_quiet_cnt <= r_quiet_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky flags: a new error event in the same cycle as clear_err wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (clear_err) begin
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_busy && sample_tick && enable)
                r_overrun <= 1'b1;
            if (w_last && w_lead_err)
                r_frame_err <= 1'b1;
        end
    end

    assign adc_cs_n   = r_cs_n;
    assign adc_sclk   = r_sclk;
    assign adc_data   = r_data;
    assign data_valid = r_valid;
    assign busy       = w_busy;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Self-checking bench for adc_spi_capture: ADC serial model plus a cycle-level
// expectation of frame timing, delivered data and sticky flags.
module tb_adc_spi_capture;

    localparam int CLK_DIV = 2;
    localparam int LAT     = 32 * CLK_DIV + 2;   // tick to data_valid
    localparam int SPACING = LAT + 4;            // minimum overrun-free tick spacing

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        sample_tick = 1'b0;
    logic        clear_err = 1'b0;
    logic        adc_sdata = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] adc_data;
    logic        data_valid;
    logic        busy;
    logic        overrun;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] adc_q[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    int          rise_cyc[$];
    int          vld_cyc[$];
    logic [11:0] got_data[$];
    int          cs_falls = 0;

    adc_spi_capture dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_tick (sample_tick),
        .clear_err   (clear_err),
        .adc_sdata   (adc_sdata),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_data    (adc_data),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: MSB presented when cs_n falls, next bit after each sclk rise.
    always @(negedge clk) begin
        if (prev_cs && !adc_cs_n) begin
            cs_falls++;
            cur_word = 16'h0;
            if (adc_q.size() > 0) cur_word = adc_q.pop_front();
            bit_idx   = 15;
            adc_sdata = cur_word[15];
        end else if (!adc_cs_n && adc_sclk && !prev_sclk) begin
            rise_cyc.push_back(cyc);
            if (bit_idx > 0) begin
                bit_idx--;
                adc_sdata = cur_word[bit_idx];
            end
        end
        if (data_valid) begin
            vld_cyc.push_back(cyc);
            got_data.push_back(adc_data);
        end
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test sequence");
        $fatal(1);
    end

    task automatic at_cycle(input int x);
        @(negedge clk);
        while (cyc < x) @(negedge clk);
    endtask

    task automatic pulse_tick(output int t);
        @(negedge clk);
        sample_tick = 1'b1;
        t = cyc;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic test_reset();
        at_cycle(3);
        checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
        checks++; if (adc_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", adc_sclk); end
        checks++; if (adc_data !== 12'h0) begin errors++; $display("FAIL reset_data: got %h want 000", adc_data); end
        checks++; if ({data_valid, busy, overrun, frame_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got v/b/o/e=%b want 0000", {data_valid, busy, overrun, frame_err});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int t;
        int v0;
        adc_q.push_back(16'h0ABC);
        rise_cyc.delete();
        v0 = vld_cyc.size();
        at_cycle(9);
        pulse_tick(t);
        checks++; if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL basic_cs_fall: got %b want 0 at T+1", adc_cs_n); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", busy); end
        at_cycle(t + LAT - 1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b want 0", data_valid); end
        at_cycle(t + LAT);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", data_valid); end
        checks++; if (adc_data !== 12'hABC) begin errors++; $display("FAIL basic_data: got %h want abc", adc_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", frame_err); end
        checks++; if ({adc_cs_n, adc_sclk} !== 2'b11) begin errors++; $display("FAIL basic_done_pins: got %b want 11", {adc_cs_n, adc_sclk}); end
        at_cycle(t + LAT + 1);
        checks++; if (data_valid !== 1'b0 || adc_data !== 12'hABC) begin
            errors++; $display("FAIL basic_hold: got valid=%b data=%h want 0/abc", data_valid, adc_data);
        end
        at_cycle(t + LAT + 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_quiet: got %b want 1", busy); end
        at_cycle(t + LAT + 5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        checks++; if (rise_cyc.size() !== 16) begin errors++; $display("FAIL basic_rise_count: got %0d want 16", rise_cyc.size()); end
        for (int k = 0; k < 16 && k < rise_cyc.size(); k++) begin
            checks++;
            if (rise_cyc[k] !== t + 1 + (2 * k + 2) * CLK_DIV) begin
                errors++; $display("FAIL basic_rise_time[%0d]: got %0d want %0d", k, rise_cyc[k], t + 1 + (2 * k + 2) * CLK_DIV);
            end
        end
        checks++; if (vld_cyc.size() !== v0 + 1) begin errors++; $display("FAIL basic_valid_count: got %0d want %0d", vld_cyc.size(), v0 + 1); end
    endtask

    task automatic test_frame_err();
        int t;
        logic [15:0] w;
        adc_q.push_back(16'h8123);
        pulse_tick(t);
        at_cycle(t + LAT);
        checks++; if (adc_data !== 12'h123) begin errors++; $display("FAIL ferr_data: got %h want 123", adc_data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        at_cycle(t + SPACING);
        pulse_clear();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
        // clear_err in the same cycle as the error event: error must win
        w = {4'($urandom_range(1, 15)), 12'($urandom())};
        adc_q.push_back(w);
        pulse_tick(t);
        at_cycle(t + LAT - 1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_pre: got %b want 0", frame_err); end
        clear_err = 1'b1;
        at_cycle(t + LAT);
        clear_err = 1'b0;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_vs_clear: got %b want 1", frame_err); end
        checks++; if (adc_data !== w[11:0]) begin errors++; $display("FAIL ferr_data2: got %h want %h", adc_data, w[11:0]); end
        at_cycle(t + SPACING);
        pulse_clear();
    endtask

    task automatic test_random_frames();
        logic [11:0] d[8];
        int t0;
        int tt;
        int v0;
        d[0] = 12'h000; d[1] = 12'hFFF; d[2] = 12'h555; d[3] = 12'hAAA;
        for (int i = 4; i < 8; i++) d[i] = 12'($urandom());
        for (int i = 0; i < 8; i++) adc_q.push_back({4'h0, d[i]});
        v0 = vld_cyc.size();
        pulse_tick(t0);
        for (int i = 1; i < 8; i++) begin
            at_cycle(t0 + SPACING * i - 1);
            pulse_tick(tt);
        end
        at_cycle(t0 + SPACING * 7 + SPACING + 2);
        checks++; if (vld_cyc.size() !== v0 + 8) begin errors++; $display("FAIL rand_count: got %0d want %0d", vld_cyc.size() - v0, 8); end
        for (int i = 0; i < 8 && v0 + i < vld_cyc.size(); i++) begin
            checks++;
            if (got_data[v0 + i] !== d[i] || vld_cyc[v0 + i] !== t0 + SPACING * i + LAT) begin
                errors++; $display("FAIL rand_frame[%0d]: got %h @%0d want %h @%0d", i, got_data[v0 + i], vld_cyc[v0 + i], d[i], t0 + SPACING * i + LAT);
            end
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun: got %b want 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rand_ferr: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
        int t;
        int t2;
        int v0;
        int c0;
        logic [11:0] a;
        a = 12'($urandom());
        adc_q.push_back({4'h0, a});
        v0 = vld_cyc.size();
        c0 = cs_falls;
        pulse_tick(t);
        at_cycle(t + 19);
        pulse_tick(t2);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        at_cycle(t + SPACING + 5);
        checks++; if (vld_cyc.size() !== v0 + 1) begin errors++; $display("FAIL ovr_valid_count: got %0d want %0d", vld_cyc.size() - v0, 1); end
        checks++; if (got_data.size() > v0 && got_data[v0] !== a) begin errors++; $display("FAIL ovr_data: got %h want %h", got_data[v0], a); end
        checks++; if (cs_falls !== c0 + 1) begin errors++; $display("FAIL ovr_frames: got %0d want %0d", cs_falls - c0, 1); end
        pulse_clear();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        // tick in the last busy cycle is still an overrun and is dropped
        adc_q.push_back(16'h0123);
        c0 = cs_falls;
        pulse_tick(t);
        at_cycle(t + SPACING - 2);
        pulse_tick(t2);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_last_quiet: got %b want 1", overrun); end
        at_cycle(t + SPACING + 4);
        checks++; if (cs_falls !== c0 + 1 || adc_cs_n !== 1'b1) begin
            errors++; $display("FAIL ovr_last_dropped: got frames=%0d cs_n=%b want 1/1", cs_falls - c0, adc_cs_n);
        end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        int t;
        int v0;
        logic [11:0] w2;
        adc_q.push_back({4'h0, 12'($urandom())});
        v0 = vld_cyc.size();
        pulse_tick(t);
        at_cycle(t + 40);
        #2 reset = 1'b1;
        #1;
        checks++; if ({adc_cs_n, adc_sclk, busy, data_valid} !== 4'b1100) begin
            errors++; $display("FAIL rst_mid_pins: got cs/sclk/busy/valid=%b want 1100", {adc_cs_n, adc_sclk, busy, data_valid});
        end
        at_cycle(t + 43);
        reset = 1'b0;
        at_cycle(t + SPACING + 10);
        checks++; if (vld_cyc.size() !== v0) begin errors++; $display("FAIL rst_mid_no_valid: got %0d want 0", vld_cyc.size() - v0); end
        checks++; if (adc_data !== 12'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 000", adc_data); end
        w2 = 12'($urandom());
        adc_q.push_back({4'h0, w2});
        pulse_tick(t);
        at_cycle(t + LAT);
        checks++; if (data_valid !== 1'b1 || adc_data !== w2) begin
            errors++; $display("FAIL rst_mid_clean: got valid=%b data=%h want 1/%h", data_valid, adc_data, w2);
        end
        at_cycle(t + SPACING);
    endtask

    task automatic test_enable();
        int t;
        int t2;
        int c0;
        int cs_bad;
        logic [11:0] w;
        enable = 1'b0;
        c0 = cs_falls;
        cs_bad = 0;
        pulse_tick(t);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (adc_cs_n !== 1'b1 || busy !== 1'b0) cs_bad++;
        end
        checks++; if (cs_bad !== 0 || cs_falls !== c0) begin errors++; $display("FAIL en_ignored: got bad=%0d frames=%0d want 0/0", cs_bad, cs_falls - c0); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL en_no_overrun: got %b want 0", overrun); end
        enable = 1'b1;
        w = 12'($urandom());
        adc_q.push_back({4'h0, w});
        pulse_tick(t);
        at_cycle(t + 30);
        enable = 1'b0;
        at_cycle(t + 39);
        pulse_tick(t2);  // busy but disabled: not an overrun
        at_cycle(t + LAT);
        checks++; if (data_valid !== 1'b1 || adc_data !== w) begin
            errors++; $display("FAIL en_drop_mid: got valid=%b data=%h want 1/%h", data_valid, adc_data, w);
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL en_busy_tick: got %b want 0", overrun); end
        at_cycle(t + SPACING);
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_random_frames();
        test_overrun();
        test_reset_mid();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Front-end stage directly upstream of the reconstruction top.
- Drives the serial interface of the 12-bit modulo ADC, which produces a 16-bit frame of 4 leading zeros followed by 12 data bits, MSB first.
- Delivers each captured sample as `adc_data` plus a one-cycle `data_valid`, which feed the pipeline's `adc_in` / `start`.
- Conversions are requested by `sample_tick`, the system sample-rate strobe that also drives `clk_en` downstream.

Parameters:
- CLK_DIV, 2, `adc_sclk` half-period in `clk` cycles (≥1)
- FRAME_BITS, 16, SCLK rising edges per frame
- DATA_BITS, 12, data bits at the end of the frame
- LEAD_BITS, 4, leading bits that must be zero (FRAME_BITS−DATA_BITS)
- QUIET_CYCLES, 4, minimum `cs_n`-high time between frames, in `clk` cycles

Ports:
- clk  in  1  system clock; all registers update on the rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  capture enable; when low, ticks are ignored and not counted as overrun
- sample_tick  in  1  conversion request strobe, one cycle wide
- clear_err  in  1  clears the sticky error flags
- adc_sdata  in  1  serial data from the ADC
- adc_cs_n  out  1  chip select, active low
- adc_sclk  out  1  serial clock; idles high
- adc_data  out  DATA_BITS  last captured sample, held until the next capture
- data_valid  out  1  one-cycle pulse when `adc_data` updates
- busy  out  1  high from the cycle after an accepted tick through the end of QUIET
- overrun  out  1  sticky: a tick arrived while busy
- frame_err  out  1  sticky: a non-zero leading bit was seen in some frame

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame): `adc_cs_n`=1, `adc_sclk`=1, `adc_data`=0, `data_valid`=0, `busy`=0, `overrun`=0, `frame_err`=0, state=IDLE, all counters and the shift register=0.
- States:
  - IDLE: `sample_tick`&`enable` → SETUP.
  - SETUP: `cs_n`=0, wait CLK_DIV cycles → SHIFT.
  - SHIFT: toggle `sclk` every CLK_DIV cycles → DONE after rising edge number FRAME_BITS.
  - DONE: one cycle → QUIET.
  - QUIET: `cs_n`=1 for QUIET_CYCLES → IDLE.
- Timing, with the tick accepted in cycle T:
  - `cs_n` falls at T+1.
  - First `sclk` fall at T+1+CLK_DIV.
  - Rising edge k (k=0..15) at T+1+(2k+2)·CLK_DIV.
  - `adc_sdata` is sampled in the same cycle each rising edge is driven and shifted in at the LSB.
  - The last rising edge is at T+1+32·CLK_DIV.
- DONE cycle (T+2+32·CLK_DIV):
  - `cs_n`=1 and `sclk`=1.
  - `adc_data` = shift register[DATA_BITS−1:0].
  - `data_valid`=1 for this cycle only.
  - `frame_err` is set if shift register[FRAME_BITS−1:DATA_BITS] ≠ 0.
- Latency, tick to `data_valid`: 32·CLK_DIV+2 cycles (66 at default). Minimum tick spacing for no overrun: 32·CLK_DIV+2+QUIET_CYCLES (70 at default).
- `busy` = (state ≠ IDLE). A tick with `busy`=1 and `enable`=1 sets `overrun`; the tick is dropped and the frame in progress is unaffected.
- `adc_data` is updated only in DONE, including when `frame_err` is set; the data bits are still delivered.
- Simultaneous `clear_err` and a new error event: the error wins and the flag stays 1.
- `enable` falling mid-frame does not abort the frame; the frame completes normally.
- A tick in the last QUIET cycle counts as overrun. A tick in IDLE one cycle after QUIET ends is accepted.
- Outputs are registered; there is no combinational path from inputs to `adc_cs_n` or `adc_sclk`.

Decomposition:
- Package `adc_if_pkg`:
  - State enum (IDLE, SETUP, SHIFT, DONE, QUIET).
  - Default constants FRAME_BITS, DATA_BITS, LEAD_BITS.
  - Function computing frame latency from CLK_DIV.
- Sub-module `sclk_tick_gen`:
  - Half-period counter with a restart input.
  - Emits a one-cycle edge strobe every CLK_DIV cycles.
  - `adc_spi_capture` toggles `sclk` and counts edges from this strobe.

Test Plan:
- Reset, then a tick at cycle 10 with the ADC model driving 0x0ABC → `cs_n` low at cycle 11; 16 rising `sclk` edges, each with period 4 clk; `data_valid` at cycle 76 with `adc_data`=0xABC; `frame_err`=0; `busy` low at cycle 81.
- ADC model drives 0x8123 → `adc_data`=0x123 and `frame_err`=1. Then pulse `clear_err` → `frame_err`=0.
- Ticks every 70 cycles for 8 frames, data 0x000, 0xFFF, 0x555, 0xAAA, … → each value delivered in order; `overrun` stays 0.
- Second tick 20 cycles after the first → `overrun`=1; first frame data intact; exactly one `data_valid`.
- Assert `reset` at cycle 40 of a frame → same cycle: `cs_n`=1, `sclk`=1, `busy`=0; no `data_valid`; a tick after release starts a clean frame with correct data.
- Tick with `enable`=0 → no `cs_n` activity and `overrun` stays 0. Then drop `enable` mid-frame → the frame completes and `data_valid` still pulses.
